// File: rtl/timer_pkg.sv
// Shared constants for the timer bank: register offsets, CTRL bit positions, channel stride.
// Capture-related constants exist only when TIMER_BANK_CAPTURE_EN is defined.
package timer_pkg;

    localparam int unsigned ChStride = 32'h20;
    localparam int unsigned ChIdxW   = 3;

    localparam logic [4:0] OffCtrl  = 5'h00;
    localparam logic [4:0] OffPresc = 5'h04;
    localparam logic [4:0] OffCmp   = 5'h08;
    localparam logic [4:0] OffCnt   = 5'h0C;
    localparam logic [4:0] OffCap   = 5'h10;

    localparam logic [7:0] AddrStatus = 8'hF0;

    localparam int unsigned CtrlEn      = 0;
    localparam int unsigned CtrlOneshot = 1;
    localparam int unsigned CtrlIrqEn   = 2;
    localparam int unsigned CtrlToggle  = 3;
    localparam int unsigned CtrlW       = 4;

`ifdef TIMER_BANK_CAPTURE_EN
    localparam int unsigned CapStatusLsb = 8;
`endif

    function automatic logic [ChIdxW-1:0] ch_of(logic [7:0] addr);
        return ChIdxW'(32'(addr) / ChStride);
    endfunction

    // Word index of a register inside its channel window.
    function automatic logic [2:0] word_of(logic [7:0] addr);
        return 3'((32'(addr) % ChStride) >> 2);
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Peripheral bus bundle for the timer bank: select, write strobe, address, data.
interface timer_bank_if;

    logic        sel;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/timer_bank_channel.sv
// One compare-timer channel: prescaler, counter, compare match, cmp_out and pending flag.
// With TIMER_BANK_CAPTURE_EN defined, also a synchronised rising-edge input capture.
module timer_bank_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_ctrl,
    input  logic               wr_presc,
    input  logic               wr_cmp,
    input  logic               wr_cnt,
    input  logic [31:0]        wdata,
    input  logic               clr_pending,
`ifdef TIMER_BANK_CAPTURE_EN
    input  logic               cap_in,
    input  logic               clr_cap,
    output logic [WIDTH-1:0]   cap,
    output logic               cap_pending,
`endif
    output logic [CtrlW-1:0]   ctrl,
    output logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   cmp,
    output logic [WIDTH-1:0]   cnt,
    output logic               cmp_out,
    output logic               pending
);

    logic [CtrlW-1:0]   ctrl_q;
    logic [PRESC_W-1:0] presc_q, pcnt_q;
    logic [WIDTH-1:0]   cmp_q, cnt_q;
    logic               cmp_out_q, pending_q;
    logic               tick, match;

    assign tick  = ctrl_q[CtrlEn] && (pcnt_q == presc_q);
    assign match = tick && (cnt_q == cmp_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            cmp_q     <= '0;
            cnt_q     <= '0;
            cmp_out_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= wdata[CtrlW-1:0];
            end else if (match && ctrl_q[CtrlOneshot]) begin
                ctrl_q[CtrlEn] <= 1'b0;
            end
            if (wr_presc) presc_q <= wdata[PRESC_W-1:0];
            if (wr_cmp)   cmp_q   <= wdata[WIDTH-1:0];

            if (wr_cnt) begin
                cnt_q <= wdata[WIDTH-1:0];
            end else if (match) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= cnt_q + WIDTH'(1);
            end

            // Any timing reconfiguration restarts the prescale period.
            if (wr_ctrl || wr_presc || wr_cnt || !ctrl_q[CtrlEn] || tick) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + PRESC_W'(1);
            end

            if (match) begin
                pending_q <= 1'b1;
            end else if (clr_pending) begin
                pending_q <= 1'b0;
            end

            if (ctrl_q[CtrlToggle]) begin
                if (match) cmp_out_q <= ~cmp_out_q;
            end else begin
                cmp_out_q <= match;
            end
        end
    end

    assign ctrl    = ctrl_q;
    assign presc   = presc_q;
    assign cmp     = cmp_q;
    assign cnt     = cnt_q;
    assign cmp_out = cmp_out_q;
    assign pending = pending_q;

`ifdef TIMER_BANK_CAPTURE_EN
    // [0] first sync stage, [1] second sync stage, [2] previous synchronised level.
    logic [2:0]       cap_sync_q;
    logic [WIDTH-1:0] cap_q;
    logic             cap_pending_q;
    logic             cap_edge;

    assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_sync_q    <= '0;
            cap_q         <= '0;
            cap_pending_q <= 1'b0;
        end else begin
            cap_sync_q <= {cap_sync_q[1:0], cap_in};
            if (cap_edge) cap_q <= cnt_q;
            if (cap_edge) begin
                cap_pending_q <= 1'b1;
            end else if (clr_cap) begin
                cap_pending_q <= 1'b0;
            end
        end
    end

    assign cap         = cap_q;
    assign cap_pending = cap_pending_q;
`endif

endmodule

// File: rtl/timer_bank.sv
// Multi-channel compare timer: NUM_CH channels, bus decode, STATUS W1C, read mux and irq.
// Optional input capture per channel is enabled by defining TIMER_BANK_CAPTURE_EN.
module timer_bank
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    timer_bank_if.slave       bus,
`ifdef TIMER_BANK_CAPTURE_EN
    input  logic [NUM_CH-1:0] cap_in,
`endif
    output logic [NUM_CH-1:0] cmp_out,
    output logic              irq
);

    logic                            wr, rd, status_hit;
    logic [NUM_CH-1:0]               pending, irq_en, clr_pending, irq_src;
    logic [NUM_CH-1:0][CtrlW-1:0]    ctrl_v;
    logic [NUM_CH-1:0][PRESC_W-1:0]  presc_v;
    logic [NUM_CH-1:0][WIDTH-1:0]    cmp_v, cnt_v;
    logic [31:0]                     rd_val, rdata_q;
    logic                            irq_q;
    logic                            unused_addr_lsb;

    assign wr              = bus.sel & bus.we;
    assign rd              = bus.sel & ~bus.we;
    assign status_hit      = bus.addr[7:2] == AddrStatus[7:2];
    assign clr_pending     = (wr && status_hit) ? bus.wdata[NUM_CH-1:0] : '0;
    assign unused_addr_lsb = ^bus.addr[1:0];

`ifdef TIMER_BANK_CAPTURE_EN
    logic [NUM_CH-1:0]            cap_pending, clr_cap;
    logic [NUM_CH-1:0][WIDTH-1:0] cap_v;

    assign clr_cap = (wr && status_hit) ? bus.wdata[CapStatusLsb +: NUM_CH] : '0;
    assign irq_src = (pending | cap_pending) & irq_en;
`else
    assign irq_src = pending & irq_en;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_wr;
        assign ch_wr     = wr && (ch_of(bus.addr) == ChIdxW'(g));
        assign irq_en[g] = ctrl_v[g][CtrlIrqEn];

        timer_bank_channel #(
            .WIDTH   (WIDTH),
            .PRESC_W (PRESC_W)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .wr_ctrl     (ch_wr && (word_of(bus.addr) == OffCtrl[4:2])),
            .wr_presc    (ch_wr && (word_of(bus.addr) == OffPresc[4:2])),
            .wr_cmp      (ch_wr && (word_of(bus.addr) == OffCmp[4:2])),
            .wr_cnt      (ch_wr && (word_of(bus.addr) == OffCnt[4:2])),
            .wdata       (bus.wdata),
            .clr_pending (clr_pending[g]),
`ifdef TIMER_BANK_CAPTURE_EN
            .cap_in      (cap_in[g]),
            .clr_cap     (clr_cap[g]),
            .cap         (cap_v[g]),
            .cap_pending (cap_pending[g]),
`endif
            .ctrl        (ctrl_v[g]),
            .presc       (presc_v[g]),
            .cmp         (cmp_v[g]),
            .cnt         (cnt_v[g]),
            .cmp_out     (cmp_out[g]),
            .pending     (pending[g])
        );
    end

    always_comb begin
        rd_val = '0;
        if (status_hit) begin
            rd_val[NUM_CH-1:0] = pending;
`ifdef TIMER_BANK_CAPTURE_EN
            rd_val[CapStatusLsb +: NUM_CH] = cap_pending;
`endif
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_of(bus.addr) == ChIdxW'(n)) begin
                    case (word_of(bus.addr))
                        OffCtrl[4:2]:  rd_val[CtrlW-1:0]   = ctrl_v[n];
                        OffPresc[4:2]: rd_val[PRESC_W-1:0] = presc_v[n];
                        OffCmp[4:2]:   rd_val[WIDTH-1:0]   = cmp_v[n];
                        OffCnt[4:2]:   rd_val[WIDTH-1:0]   = cnt_v[n];
                        OffCap[4:2]: begin
`ifdef TIMER_BANK_CAPTURE_EN
                            rd_val[WIDTH-1:0] = cap_v[n];
`else
                            rd_val = '0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (rd) rdata_q <= rd_val;
            irq_q <= |irq_src;
        end
    end

    assign bus.rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank (NUM_CH=3, WIDTH=8, PRESC_W=16): register table,
// corner-case sequences and randomized runs against an arithmetic timing model.
module tb_timer_bank;

    logic       clk;
    logic       reset;
    logic [2:0] cmp_out;
    logic       irq;
    int         checks;
    int         failures;
    logic [31:0] d;

    timer_bank_if bus ();

`ifdef TIMER_BANK_CAPTURE_EN
    logic [2:0] cap_in;
`endif

    timer_bank #(
        .NUM_CH  (3),
        .WIDTH   (8),
        .PRESC_W (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
`ifdef TIMER_BANK_CAPTURE_EN
        .cap_in  (cap_in),
`endif
        .cmp_out (cmp_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] v);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = v;
        step();
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] v);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        step();
        bus.sel = 1'b0;
        v = bus.rdata;
    endtask

    task automatic quiesce();
        for (int ch = 0; ch < 3; ch++) bus_wr(8'(ch * 32), 32'h0);
        bus_wr(8'hF0, 32'hFFFF);
    endtask

    // Model for a channel enabled with CNT=0 at cycle 0: ticks land on every (p+1)th cycle.
    function automatic logic exp_cmp(int c, int p, int cm, bit tog);
        int ticks;
        ticks = c / (p + 1);
        if (tog) return ((ticks / (cm + 1)) % 2) == 1;
        return (c > 0) && (c % (p + 1) == 0) && (ticks % (cm + 1) == 0);
    endfunction

    function automatic logic exp_pending(int c, int p, int cm);
        return (c / (p + 1)) >= (cm + 1);
    endfunction

    int  ch, p, cm, n, first, count;
    bit  tog, ie;
    logic [7:0] base;

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0; reset = 1'b1;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
`ifdef TIMER_BANK_CAPTURE_EN
        cap_in = '0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("reset_cmp_out", cmp_out, 0);
        check("reset_irq", irq, 0);
        check("reset_rdata", bus.rdata, 0);
        bus_rd(8'hF0, d); check("reset_status", d, 0);
        bus_rd(8'h00, d); check("reset_ctrl0", d, 0);
        bus_rd(8'h2C, d); check("reset_cnt1", d, 0);

        vecs[0]  = '{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0000_FFFF};
        vecs[1]  = '{1'b1, 8'h28, 32'h0000_1234, 32'h0000_0034};
        vecs[2]  = '{1'b1, 8'h4C, 32'h0000_01FF, 32'h0000_00FF};
        vecs[3]  = '{1'b1, 8'h00, 32'hFFFF_FFF2, 32'h0000_0002};
        vecs[4]  = '{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{1'b1, 8'h60, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[6]  = '{1'b1, 8'hE4, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{1'b1, 8'h1C, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{1'b1, 8'h45, 32'h0000_00AB, 32'h0000_00AB};
        vecs[9]  = '{1'b1, 8'h2B, 32'h0000_00C3, 32'h0000_00C3};
        vecs[10] = '{1'b1, 8'hF0, 32'h0000_00FF, 32'h0000_0000};
        vecs[11] = '{1'b0, 8'h00, 32'h0,         32'h0000_0002};
        vecs[12] = '{1'b0, 8'h04, 32'h0,         32'h0000_FFFF};
        vecs[13] = '{1'b0, 8'h4C, 32'h0,         32'h0000_00FF};
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) bus_wr(vecs[i].addr, vecs[i].wdata);
            bus_rd(vecs[i].addr, d);
            check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
        end

        bus_rd(8'h04, d);
        bus.addr = 8'hF0;
        repeat (2) step();
        check("rdata_hold", bus.rdata, 32'hFFFF);

        // One-shot on ch1: PRESC=2, CMP=1 -> one match in cycle 5, pulse in cycle 6.
        quiesce();
        bus_wr(8'h24, 2); bus_wr(8'h28, 1); bus_wr(8'h2C, 0); bus_wr(8'h20, 7);
        first = -1; count = 0;
        for (int c = 0; c < 14; c++) begin
            if (cmp_out[1]) begin
                count++;
                if (first < 0) first = c;
            end
            if (c == 6) check("oneshot_irq_before", irq, 0);
            if (c == 7) check("oneshot_irq_after", irq, 1);
            step();
        end
        check("oneshot_first_pulse", first, 6);
        check("oneshot_pulse_count", count, 1);
        bus_rd(8'h20, d); check("oneshot_ctrl", d, 6);
        bus_rd(8'h2C, d); check("oneshot_cnt", d, 0);
        bus_rd(8'hF0, d); check("oneshot_status", d, 2);

        // CMP=0xFF from CNT=0xFE: matches on the second tick.
        quiesce();
        bus_wr(8'h04, 0); bus_wr(8'h08, 8'hFF); bus_wr(8'h0C, 8'hFE); bus_wr(8'h00, 1);
        step();
        bus_wr(8'h00, 0);
        check("max_cmp_pulse", cmp_out, 1);
        bus_rd(8'h0C, d); check("max_cmp_cnt", d, 0);
        bus_rd(8'hF0, d); check("max_cmp_status", d, 1);

        // CNT=0xFF below CMP wraps to 0 with no flag.
        quiesce();
        bus_wr(8'h08, 8'h10); bus_wr(8'h0C, 8'hFF); bus_wr(8'h00, 1);
        bus_wr(8'h00, 0);
        bus_rd(8'h0C, d); check("wrap_cnt", d, 0);
        bus_rd(8'hF0, d); check("wrap_status", d, 0);

        // W1C in the same cycle as a match: the set wins.
        quiesce();
        bus_wr(8'h04, 0); bus_wr(8'h08, 3); bus_wr(8'h0C, 0); bus_wr(8'h00, 1);
        repeat (3) step();
        bus_wr(8'hF0, 1);
        bus_wr(8'h00, 0);
        bus_rd(8'hF0, d); check("w1c_conflict", d, 1);
        bus_wr(8'hF0, 1);
        bus_rd(8'hF0, d); check("w1c_clear", d, 0);

        for (int t = 0; t < 10; t++) begin
            ch  = $urandom_range(0, 2);
            p   = $urandom_range(0, 3);
            cm  = $urandom_range(0, 5);
            tog = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            n   = $urandom_range(15, 40);
            base = 8'(ch * 32);
            quiesce();
            bus_wr(base + 8'h04, 32'(p));
            bus_wr(base + 8'h08, 32'(cm));
            bus_wr(base + 8'h0C, 0);
            bus_wr(base, {28'b0, tog, ie, 1'b0, 1'b1});
            for (int c = 0; c < n; c++) begin
                check($sformatf("rand%0d_cmp_out_c%0d", t, c), cmp_out,
                      32'(exp_cmp(c, p, cm, tog)) << ch);
                check($sformatf("rand%0d_irq_c%0d", t, c), irq,
                      32'(ie && exp_pending(c - 1, p, cm)));
                step();
            end
            bus_rd(base + 8'h0C, d);
            check($sformatf("rand%0d_cnt", t), d, 32'((n / (p + 1)) % (cm + 1)));
            bus_rd(8'hF0, d);
            check($sformatf("rand%0d_status", t), d,
                  exp_pending(n + 1, p, cm) ? (32'h1 << ch) : 32'h0);
        end

`ifdef TIMER_BANK_CAPTURE_EN
        quiesce();
        bus_wr(8'h04, 0); bus_wr(8'h08, 8'hFF); bus_wr(8'h0C, 8'h20); bus_wr(8'h00, 1);
        cap_in[0] = 1'b1;
        repeat (4) step();
        bus_wr(8'h00, 0);
        bus_rd(8'h10, d);
        checks++;
        if (d != 32'h22 && d != 32'h23) begin
            failures++;
            $display("FAIL cap_value: got 0x%0h, expected 0x22 or 0x23", d);
        end
        bus_rd(8'hF0, d); check("cap_status", d & 32'h100, 32'h100);
        cap_in = '0;
`endif

        // Reset mid-count with toggle output high and irq asserted.
        quiesce();
        bus_wr(8'h44, 0); bus_wr(8'h48, 3); bus_wr(8'h4C, 0); bus_wr(8'h40, 32'hD);
        repeat (5) step();
        bus_rd(8'h40, d);
        check("pre_reset_rdata", d, 32'hD);
        check("pre_reset_cmp_out", cmp_out, 3'b100);
        check("pre_reset_irq", irq, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_cmp_out", cmp_out, 0);
        check("async_reset_irq", irq, 0);
        check("async_reset_rdata", bus.rdata, 0);
        #2 reset = 1'b0;
        step();
        bus_rd(8'h4C, d); check("post_reset_cnt2", d, 0);
        bus_rd(8'h40, d); check("post_reset_ctrl2", d, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised multi-channel compare timer peripheral for the microcontroller.
- Generalises the fixed TIM1/TIM2/TIM3 compare timers into NUM_CH identical channels.
- Each channel has a prescaler, a compare register, continuous or one-shot mode, a compare output and an interrupt pending flag.
- Sits on the peripheral bus and drives the top-level compare pins and the interrupt controller.

Parameters:
- NUM_CH, 3, number of timer channels (1..7).
- WIDTH, 32, counter and compare width (8..32).
- PRESC_W, 16, prescaler width (1..32).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sel  input  1  bus select for this peripheral.
- we  input  1  write enable; qualified by sel.
- addr  input  8  byte address, word aligned; addr[1:0] ignored.
- wdata  input  32  write data.
- rdata  output  32  read data, registered.
- cmp_out  output  NUM_CH  per-channel compare output.
- irq  output  1  OR of all enabled pending flags.

Behaviour:
- Reset: all registers 0, rdata=0, cmp_out=0, irq=0, prescalers 0.
- Register map, channel n at base n*0x20:
  - +0x00 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN, bit3 TOGGLE.
  - +0x04 PRESC (PRESC_W bits).
  - +0x08 CMP (WIDTH bits).
  - +0x0C CNT (WIDTH bits, R/W).
  - 0xF0 STATUS: bit n = pending[n]. Write-1-to-clear; reads return 0 in bits >= NUM_CH.
- Unmapped addresses: read 0, writes ignored. Narrow registers zero-extend on read; upper write bits are dropped.
- Read latency: rdata is valid 1 cycle after sel=1, we=0. rdata holds its value when sel=0.
- Prescaler: while EN=1, pcnt counts 0..PRESC. A tick occurs in the cycle pcnt==PRESC, and pcnt returns to 0. PRESC=0 gives a tick every cycle. EN=0 holds pcnt at 0 and CNT frozen.
- On tick:
  - If CNT==CMP: CNT<=0 and pending[n]<=1.
    - TOGGLE=0: cmp_out[n] is high for exactly the one following cycle.
    - TOGGLE=1: cmp_out[n] inverts and holds.
    - ONESHOT=1: EN is also cleared.
  - Otherwise CNT<=CNT+1, modulo 2^WIDTH. Wrap-around sets no flag.
- CMP=0: match on every tick, giving a period of PRESC+1 cycles.
- Writing CTRL, PRESC or CNT clears pcnt to 0.
- Same-cycle conflicts:
  - A CNT write beats the tick update.
  - A hardware set of pending beats a W1C clear.
  - A CTRL write beats the one-shot EN clear.
- Clearing EN with TOGGLE=1 leaves cmp_out at its current level. Clearing TOGGLE forces cmp_out to 0.
- irq is registered: irq <= |(pending & IRQ_EN vector). It rises 1 cycle after pending sets.
- Reset mid-count returns everything to the reset state immediately (asynchronous).

Optional Feature:
- Macro: TIMER_BANK_CAPTURE_EN.
- With the macro defined:
  - Extra port cap_in (input, NUM_CH) and register +0x10 CAP (WIDTH bits, read-only).
  - cap_in passes through a 2-flop synchroniser, then a rising-edge detect.
  - A detected edge latches the current CNT into CAP and sets STATUS bit 8+n.
  - That STATUS bit is W1C and ORs into irq when IRQ_EN=1.
  - Total capture latency from a cap_in edge to CAP update is 3 cycles.
- Without the macro: no cap_in port; +0x10 reads 0; STATUS bits 8+ read 0.

Decomposition:
- Package timer_pkg holds:
  - Register offset constants (CTRL, PRESC, CMP, CNT, CAP, STATUS).
  - CTRL bit-index constants.
  - Channel stride 0x20.
- Sub-module timer_bank_channel holds one channel's registers, prescaler, compare logic, cmp_out and pending. The top generates NUM_CH instances plus the bus decode, STATUS and rdata mux.

Test Plan:
- PRESC=0, CMP=4, CTRL=EN -> cmp_out[0] pulses 1 cycle every 5 cycles; STATUS=0x1 after the first match.
- PRESC=2, CMP=1, CTRL=EN|ONESHOT|IRQ_EN on ch1 -> a single match after 6 cycles, irq=1 one cycle later, CTRL reads back 0x6, CNT stays 0.
- ch2 with TOGGLE=1, CMP=3, PRESC=0 -> cmp_out[2] is a square wave with period 8 cycles; clearing TOGGLE forces it to 0.
- WIDTH=8, CMP=0xFF, then write CNT=0xFE -> match on the 2nd tick, CNT=0. With CMP=0x10 and CNT=0xFF -> wraps to 0 with no flag.
- Write 1 to STATUS bit0 in the same cycle as a ch0 match -> pending stays 1. Assert reset mid-count -> all outputs 0 immediately.
- TIMER_BANK_CAPTURE_EN: CNT running at 0x20, raise cap_in[0] -> CAP reads 0x22 or 0x23 (3-cycle latency) and STATUS bit8=1.
